// File: rtl/param_serializer_pkg.sv
// param_serializer_pkg: shared state encodings and sizing helper for the serializer
package param_serializer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        WAIT = 2'b10,
        SEND = 2'b11
    } state_e;

    // Width needed to hold 0..n-1, never narrower than one bit
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/param_serializer_fsm_if.sv
// param_serializer_fsm_if: producer/link side signals of the serializer
interface param_serializer_fsm_if #(parameter int WIDTH = 16);

    logic             start;
    logic             ss;
    logic [WIDTH-1:0] data_input;
    logic             ready;
    logic             data_output;
    logic             bit_strobe;
    logic             data_sent;
    logic             aborted;
    logic [1:0]       state_q;

    modport master (
        output start, ss, data_input,
        input  ready, data_output, bit_strobe, data_sent, aborted, state_q
    );

    modport slave (
        input  start, ss, data_input,
        output ready, data_output, bit_strobe, data_sent, aborted, state_q
    );

endinterface

// File: rtl/serializer_bit_timer.sv
// serializer_bit_timer: bit-period divider and bit counter for one frame
module serializer_bit_timer
    import param_serializer_pkg::*;
#(
    parameter int WIDTH        = 16,
    parameter int CLKS_PER_BIT = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic bit_strobe,
    output logic bit_done,
    output logic frame_done
);

    localparam int DW = clog2_min1(CLKS_PER_BIT);
    localparam int BW = clog2_min1(WIDTH);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    logic [DW-1:0] div_q, div_d;
    logic [BW-1:0] bit_q, bit_d;

    // Divider wraps every CLKS_PER_BIT clocks; bit counter advances on each wrap
    always_comb begin
        bit_strobe = enable && div_q == '0;
        bit_done   = enable && div_q == DIV_LAST;
        frame_done = bit_done && bit_q == BIT_LAST;
        div_d      = clear ? '0 : !enable ? div_q : bit_done ? '0 : div_q + 1'b1;
        bit_d      = clear ? '0 : bit_done ? bit_q + 1'b1 : bit_q;
    end

    // Counter registers
    always_ff @(posedge clock) begin
        if (reset) begin
            div_q <= '0;
            bit_q <= '0;
        end else begin
            div_q <= div_d;
            bit_q <= bit_d;
        end
    end

endmodule

// File: rtl/param_serializer_fsm.sv
// param_serializer_fsm: parallel-in/serial-out serializer gated by active-low slave select
module param_serializer_fsm
    import param_serializer_pkg::*;
#(
    parameter int WIDTH        = 16,
    parameter int CLKS_PER_BIT = 1,
    parameter bit MSB_FIRST    = 1'b1,
    parameter bit IDLE_LEVEL   = 1'b0,
    parameter bit ABORT_ON_SS  = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset,
    param_serializer_fsm_if.slave bus
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             data_sent_q, data_sent_d;
    logic             aborted_q, aborted_d;
    logic             bit_done, frame_done, strobe;

    // Counters run only in SEND and sit at zero otherwise, so entering SEND starts a fresh frame
    serializer_bit_timer #(
        .WIDTH        (WIDTH),
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_timer (
        .clock      (clock),
        .reset      (reset),
        .clear      (state_q != SEND),
        .enable     (state_q == SEND),
        .bit_strobe (strobe),
        .bit_done   (bit_done),
        .frame_done (frame_done)
    );

    // Next state, shift register and completion pulses; abort wins over completion
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        data_sent_d = 1'b0;
        aborted_d   = 1'b0;
        case (state_q)
            IDLE: if (bus.start) begin
                shift_d = bus.data_input;
                state_d = LOAD;
            end
            LOAD: state_d = WAIT;
            WAIT: if (!bus.ss) state_d = SEND;
            SEND: if (ABORT_ON_SS && bus.ss) begin
                state_d   = IDLE;
                aborted_d = 1'b1;
            end else begin
                shift_d     = !bit_done ? shift_q : MSB_FIRST ? shift_q << 1 : shift_q >> 1;
                state_d     = frame_done ? IDLE : SEND;
                data_sent_d = frame_done;
            end
        endcase
    end

    // State, data and pulse registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            data_sent_q <= 1'b0;
            aborted_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            data_sent_q <= data_sent_d;
            aborted_q   <= aborted_d;
        end
    end

    assign bus.ready       = state_q == IDLE;
    assign bus.data_output = state_q == IDLE ? IDLE_LEVEL : MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0];
    assign bus.bit_strobe  = strobe;
    assign bus.data_sent   = data_sent_q;
    assign bus.aborted     = aborted_q;
    assign bus.state_q     = state_q;

endmodule

// File: tb/tb_param_serializer_fsm.sv
// tb_param_serializer_fsm: two configurations checked every cycle against a frame-level model
module tb_param_serializer_fsm;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;

    always #5 clk = ~clk;

    param_serializer_fsm_if #(.WIDTH(16)) ia ();
    param_serializer_fsm_if #(.WIDTH(8))  ib ();

    param_serializer_fsm #(
        .WIDTH(16), .CLKS_PER_BIT(1), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0), .ABORT_ON_SS(1'b1)
    ) dut_a (.clock(clk), .reset(rst), .bus(ia));

    param_serializer_fsm #(
        .WIDTH(8), .CLKS_PER_BIT(3), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1), .ABORT_ON_SS(1'b0)
    ) dut_b (.clock(clk), .reset(rst), .bus(ib));

    function automatic int pw(int d); return d != 0 ? 8 : 16; endfunction
    function automatic int pc(int d); return d != 0 ? 3 : 1; endfunction
    function automatic bit pm(int d); return d == 0; endfunction
    function automatic bit pi(int d); return d != 0; endfunction
    function automatic bit pa(int d); return d == 0; endfunction

    // Model: mode 0 idle, 1 load, 2 wait, 3 send; t counts clocks spent in send
    int          m_mode [2] = '{0, 0};
    int          m_t    [2] = '{0, 0};
    logic [15:0] m_word [2] = '{16'h0, 16'h0};
    bit          m_sent [2] = '{0, 0};
    bit          m_ab   [2] = '{0, 0};

    task automatic cmp(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic step(int d, bit r, bit st, bit s, logic [15:0] din);
        m_sent[d] = 0;
        m_ab[d]   = 0;
        if (r) begin
            m_mode[d] = 0;
            m_t[d]    = 0;
        end else if (m_mode[d] == 0) begin
            if (st) begin
                m_word[d] = din;
                m_mode[d] = 1;
            end
        end else if (m_mode[d] == 1) begin
            m_mode[d] = 2;
        end else if (m_mode[d] == 2) begin
            if (!s) begin
                m_mode[d] = 3;
                m_t[d]    = 0;
            end
        end else if (pa(d) && s) begin
            m_mode[d] = 0;
            m_ab[d]   = 1;
        end else if (m_t[d] == pw(d) * pc(d) - 1) begin
            m_mode[d] = 0;
            m_sent[d] = 1;
        end else begin
            m_t[d]++;
        end
    endtask

    task automatic chk(int d, logic rdy, logic dout, logic stb, logic snt, logic abt, logic [1:0] st);
        string p;
        int    k;
        bit    e_dout;
        p = d != 0 ? "b." : "a.";
        k = m_mode[d] == 3 ? m_t[d] / pc(d) : 0;
        e_dout = m_mode[d] == 0 ? pi(d) : m_word[d][pm(d) ? pw(d) - 1 - k : k];
        cmp({p, "ready"}, rdy, m_mode[d] == 0);
        cmp({p, "data_output"}, dout, e_dout);
        cmp({p, "bit_strobe"}, stb, m_mode[d] == 3 && m_t[d] % pc(d) == 0);
        cmp({p, "data_sent"}, snt, m_sent[d]);
        cmp({p, "aborted"}, abt, m_ab[d]);
        cmp({p, "state_q"}, st, m_mode[d]);
    endtask

    // Compare process: advance model on each rising edge, check both DUTs mid-cycle
    initial begin
        forever begin
            @(posedge clk);
            step(0, rst, ia.start, ia.ss, ia.data_input);
            step(1, rst, ib.start, ib.ss, {8'h00, ib.data_input});
            cyc++;
            @(negedge clk);
            chk(0, ia.ready, ia.data_output, ia.bit_strobe, ia.data_sent, ia.aborted, ia.state_q);
            chk(1, ib.ready, ib.data_output, ib.bit_strobe, ib.data_sent, ib.aborted, ib.state_q);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(int d);
        int n;
        n = 0;
        while (!(d != 0 ? ib.ready : ia.ready) && n < 400) begin
            tick;
            n++;
        end
        cmp("idle_timeout", n >= 400, 0);
    endtask

    logic [15:0] v16;
    logic [23:0] d24, s24;

    initial begin
        ia.start = 0; ia.ss = 1; ia.data_input = '0;
        ib.start = 0; ib.ss = 1; ib.data_input = '0;
        repeat (3) tick;
        cmp("rst_ready_a", ia.ready, 1);
        cmp("rst_state_a", ia.state_q, 0);
        cmp("rst_dout_a", ia.data_output, 0);
        cmp("rst_dout_b", ib.data_output, 1);
        cmp("rst_strobe_a", ia.bit_strobe, 0);
        rst = 0;
        tick;

        // Frame A5C3, MSB first, one clock per bit
        ia.data_input = 16'hA5C3; ia.ss = 0; ia.start = 1;
        tick;
        ia.start = 0;
        for (int k = 1; k <= 19; k++) begin
            if (k == 1) cmp("t1_load", ia.state_q, 1);
            if (k == 2) cmp("t1_wait", ia.state_q, 2);
            if (k >= 3 && k <= 18) v16[18 - k] = ia.data_output;
            if (k == 18) cmp("t1_sent_early", ia.data_sent, 0);
            if (k == 19) begin
                cmp("t1_sent", ia.data_sent, 1);
                cmp("t1_ready", ia.ready, 1);
                cmp("t1_idle_dout", ia.data_output, 0);
            end
            if (k < 19) tick;
        end
        cmp("t1_bits", v16, 16'hA5C3);

        // Byte 0x01, LSB first, three clocks per bit
        ib.data_input = 8'h01; ib.ss = 0; ib.start = 1;
        tick;
        ib.start = 0;
        for (int k = 1; k <= 27; k++) begin
            if (k >= 3 && k <= 26) begin
                d24[k - 3] = ib.data_output;
                s24[k - 3] = ib.bit_strobe;
            end
            if (k == 26) cmp("t2_sent_early", ib.data_sent, 0);
            if (k == 27) begin
                cmp("t2_sent", ib.data_sent, 1);
                cmp("t2_idle_dout", ib.data_output, 1);
            end
            if (k < 27) tick;
        end
        cmp("t2_bits", d24, 24'h000007);
        cmp("t2_strobes", s24, 24'h249249);

        // Slave select held off: frame parks in WAIT holding the first bit
        ia.ss = 1; ia.data_input = 16'h8001; ia.start = 1;
        tick;
        ia.start = 0;
        for (int k = 1; k <= 13; k++) begin
            if (k >= 2 && k <= 12) begin
                cmp("t3_wait", ia.state_q, 2);
                cmp("t3_first_bit", ia.data_output, 1);
            end
            if (k == 12) ia.ss = 0;
            if (k == 13) cmp("t3_send", ia.state_q, 3);
            if (k < 13) tick;
        end
        wait_idle(0);
        tick;

        // Abort after five bits on the aborting configuration
        ia.ss = 0; ia.data_input = 16'hF0F0; ia.start = 1;
        tick;
        ia.start = 0;
        for (int k = 1; k <= 10; k++) begin
            if (k == 8) ia.ss = 1;
            if (k == 9) begin
                cmp("t4_abort_state", ia.state_q, 0);
                cmp("t4_aborted", ia.aborted, 1);
                cmp("t4_no_sent", ia.data_sent, 0);
                cmp("t4_idle_dout", ia.data_output, 0);
            end
            if (k == 10) cmp("t4_abort_pulse", ia.aborted, 0);
            if (k < 10) tick;
        end
        ia.ss = 0;

        // Same disturbance on the non-aborting configuration completes the frame
        ib.ss = 0; ib.data_input = 8'hA6; ib.start = 1;
        tick;
        ib.start = 0;
        for (int k = 1; k <= 27; k++) begin
            if (k == 8) ib.ss = 1;
            if (k == 9) cmp("t4b_still_send", ib.state_q, 3);
            if (k == 27) cmp("t4b_sent", ib.data_sent, 1);
            if (k < 27) tick;
        end
        ib.ss = 0;
        tick;

        // Reset in the middle of a frame, then a fresh word
        ia.data_input = 16'h5A5A; ia.start = 1;
        tick;
        ia.start = 0;
        for (int k = 1; k <= 9; k++) begin
            if (k == 8) rst = 1;
            if (k == 9) begin
                cmp("t5_state", ia.state_q, 0);
                cmp("t5_ready", ia.ready, 1);
                cmp("t5_dout", ia.data_output, 0);
                cmp("t5_strobe", ia.bit_strobe, 0);
                cmp("t5_sent", ia.data_sent, 0);
                cmp("t5_aborted", ia.aborted, 0);
            end
            if (k < 9) tick;
        end
        rst = 0;
        tick;
        ia.data_input = 16'h3C5A; ia.start = 1;
        tick;
        ia.start = 0;
        for (int k = 1; k <= 19; k++) begin
            if (k >= 3 && k <= 18) v16[18 - k] = ia.data_output;
            if (k == 19) cmp("t5_fresh_sent", ia.data_sent, 1);
            if (k < 19) tick;
        end
        cmp("t5_fresh_bits", v16, 16'h3C5A);

        // Start held high: back-to-back frames, new data ignored while busy
        ia.data_input = 16'h1234; ia.start = 1;
        tick;
        ia.data_input = 16'hFFFF;
        for (int k = 1; k <= 20; k++) begin
            if (k >= 3 && k <= 18) v16[18 - k] = ia.data_output;
            if (k == 19) begin
                cmp("t6_sent", ia.data_sent, 1);
                cmp("t6_gap_idle", ia.state_q, 0);
            end
            if (k == 20) cmp("t6_reload", ia.state_q, 1);
            if (k < 20) tick;
        end
        cmp("t6_bits", v16, 16'h1234);
        ia.start = 0;
        wait_idle(0);
        wait_idle(1);

        // Randomized traffic on both configurations
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom % 300) == 0;
            ia.start = ($urandom % 3) == 0;
            ia.ss = ($urandom % 12) == 0;
            ia.data_input = 16'($urandom);
            ib.start = ($urandom % 3) == 0;
            ib.ss = ($urandom % 12) == 0;
            ib.data_input = 8'($urandom);
            tick;
        end
        rst = 0; ia.start = 0; ib.start = 0;
        repeat (3) tick;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/param_serializer_fsm.md
Name: param_serializer_fsm

Overview:
Parametrised parallel-in/serial-out serializer controlled by a four-state FSM: IDLE, LOAD, WAIT, SEND. It generalises the fixed 16-to-1 serializer with configurable word width, bit period, bit order and idle level, plus optional abort when slave-select deasserts. It sits between a parallel producer and a serial link gated by an active-low slave-select (ss) line.

Parameters:
WIDTH, 16, word width in bits; must be 2 or more.
CLKS_PER_BIT, 1, clocks each bit is held on data_output; must be 1 or more.
MSB_FIRST, 1, 1 sends data_input[WIDTH-1] first; 0 sends bit 0 first.
IDLE_LEVEL, 0, data_output value while in IDLE.
ABORT_ON_SS, 1, 1 aborts the frame if ss goes high during SEND; 0 ignores ss during SEND.

Ports:
clock  in  1  single system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  request to send; sampled only in IDLE
ss  in  1  active-low slave select; already synchronous to clock
data_input  in  WIDTH  word captured on the accepting edge
ready  out  1  high only in IDLE
data_output  out  1  serial data
bit_strobe  out  1  1-cycle pulse on the first clock of each bit in SEND
data_sent  out  1  1-cycle pulse: frame completed
aborted  out  1  1-cycle pulse: frame aborted by ss
state_q  out  2  debug: current state encoding

Behaviour:
- Interface rule: one clock; reset is synchronous and active-high.
- Reset: state=IDLE; shift register, both counters, data_sent, aborted and bit_strobe clear to 0; data_output=IDLE_LEVEL; ready=1.
- Encoding: IDLE=00, LOAD=01, WAIT=10, SEND=11. All outputs are registered or decoded from state_q only.
- IDLE: if start=1 at the edge, capture data_input into the shift register and go to LOAD. Otherwise stay in IDLE.
- LOAD: lasts exactly 1 cycle, then WAIT. data_output presents the first bit.
- WAIT: if ss=0 at the edge, go to SEND and clear both counters. Otherwise stay in WAIT with the first bit held. There is no timeout.
- SEND:
  - The divider counts 0..CLKS_PER_BIT-1.
  - On divider wrap, shift the register one place toward the output end, zero-fill, and increment the bit counter.
  - bit_strobe is 1 when divider=0.
  - After WIDTH bits (bit counter=WIDTH-1 and divider wrap), go to IDLE and pulse data_sent in the first IDLE cycle.
- Abort: if ABORT_ON_SS=1 and ss=1 at any SEND edge, go to IDLE with aborted=1 for 1 cycle and data_sent=0.
- Abort priority: an abort and completion on the same edge resolve as abort.
- Latency: start accepted at edge 0; LOAD in cycle 1; WAIT in cycle 2.
  - With ss low in cycle 2, SEND occupies cycles 3 .. 3+WIDTH*CLKS_PER_BIT-1.
  - data_sent is high in cycle 3+WIDTH*CLKS_PER_BIT.
- start outside IDLE is ignored; it is not queued. With start held high, frames run back-to-back with exactly 1 IDLE cycle between them.
- Reset asserted in any state overrides all transitions at that edge. No pulse is generated.
- data_output in IDLE is IDLE_LEVEL, including the data_sent cycle.
- Counter widths are clog2 of the count, with a minimum of 1 bit.

Decomposition:
- Package param_serializer_pkg holds the state encodings (IDLE, LOAD, WAIT, SEND) and a clog2-min-1 helper function.
- Sub-module serializer_bit_timer holds the divider and bit counter. Inputs: clear, enable. Outputs: bit_strobe, bit_done, frame_done.
- The shift register and FSM stay in the top module.

Test Plan:
1. WIDTH=16, CLKS_PER_BIT=1, MSB_FIRST=1, data 0xA5C3, start at cycle 0, ss low from cycle 2 -> data_output in cycles 3..18 is 1010010111000011; data_sent=1 in cycle 19; ready=1 from cycle 19.
2. WIDTH=8, CLKS_PER_BIT=3, MSB_FIRST=0, data 0x01 -> data_output=1 in cycles 3..5 and 0 in cycles 6..26; bit_strobe in cycles 3,6,...,24; data_sent in cycle 27.
3. ss held high for 10 cycles after LOAD -> state_q=10 throughout and data_output=first bit. ss low at cycle 12 -> SEND from cycle 13.
4. ABORT_ON_SS=1, ss rises after 5 bits -> next cycle IDLE, aborted=1, data_sent=0, data_output=IDLE_LEVEL. Repeat with ABORT_ON_SS=0 -> the full frame completes.
5. reset pulsed mid-SEND -> next cycle state_q=00, all outputs at reset values, no data_sent. A following start sends a fresh word correctly.
6. start held high continuously with words 0x1234 then 0xFFFF; start also pulsed during SEND -> the in-flight word is unaffected; the second frame begins after 1 IDLE cycle.
